lut_arbiter: RTL and testbench
==============================

LUT_ARBITER -- requirements
Module: lut_arbiter

Interface
REQ-001 Parameter SEL_W, default 5, width of the lookup-table select.
REQ-002 Parameter VAL_W, default 47, width of the lookup-table value.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req0_valid / req1_valid  input  1 each  requester N has a lookup pending.
REQ-006 Port req0_sel / req1_sel  input  SEL_W each  table index from requester N.
REQ-007 Port req0_ready / req1_ready  output  1 each  request from requester N accepted this cycle.
REQ-008 Port rsp0_valid / rsp1_valid  output  1 each  response for requester N available.
REQ-009 Port rsp_val  output  VAL_W  response data, shared by both requesters.
REQ-010 Port rsp0_ready / rsp1_ready  input  1 each  requester N consumes its response.
REQ-011 Port lut_sel  output  SEL_W  registered select driven to the combinational lookup table.
REQ-012 Port lut_val  input  VAL_W  value returned by the lookup table for lut_sel.
REQ-013 Port busy  output  1  high in any state other than IDLE.
REQ-014 Port lookup_cnt  output  16  count of completed lookups; saturates at 16'hFFFF.

Function
REQ-015 FSM states: IDLE, LOOKUP, RESP.
REQ-016 IDLE: if any reqN_valid is high, assert reqN_ready for the granted requester only (combinational from valid and grant), latch its sel into lut_sel, record the grant, and go to LOOKUP; otherwise stay in IDLE.
REQ-017 reqN_ready is low in LOOKUP and RESP.
REQ-018 LOOKUP: lasts exactly one cycle; capture lut_val into the rsp_val register; go to RESP.
REQ-019 RESP: hold rspN_valid high for the granted requester only; rsp_val and lut_sel stay stable until the handshake.
REQ-020 RESP: on rspN_valid && rspN_ready, increment lookup_cnt (saturating), deassert rspN_valid on the next cycle, and go to IDLE.
REQ-021 Latency: a request accepted in cycle T produces rspN_valid in cycle T+2. With rsp ready tied high, the minimum issue interval is 3 cycles.
REQ-022 Arbitration (with the macro defined): round-robin. When both requests are valid, grant the requester not granted last. When only one is valid, grant it regardless of history.
REQ-023 The grant pointer updates only on an accepted request.
REQ-024 A requester's valid deasserting while not granted is legal. No request is latched without its ready pulse.
REQ-025 rspN_valid for both requesters is never high in the same cycle.
REQ-026 lookup_cnt at 16'hFFFF stays 16'hFFFF on further completions.

Reset
REQ-027 On reset high at a clock edge: state becomes IDLE; lut_sel is 0; rsp_val is 0; rsp0_valid and rsp1_valid are 0; busy is 0; lookup_cnt is 0; the last-grant pointer is set to requester 1, so requester 0 wins the first contention.
REQ-028 Reset asserted in LOOKUP or RESP discards the in-flight lookup; no response is issued for it after reset.
REQ-029 reqN_ready is 0 in any cycle where reset is high.

Configuration
REQ-030 Macro LUT_ARBITER_RR_EN. When defined, arbitration is round-robin per REQ-022.
REQ-031 When LUT_ARBITER_RR_EN is not defined, arbitration is fixed priority: requester 0 always wins contention, the grant pointer is not implemented, and all other behaviour is unchanged.

Verification
REQ-032 Reset, then req0_valid=1 with req0_sel=5 at cycle T -> req0_ready=1 at T, lut_sel=5 from T+1, rsp0_valid=1 with rsp_val equal to the table entry for 5 at T+2, lookup_cnt=1 after the handshake.
REQ-033 Both valid continuously with RR on, sel0=3 and sel1=7, rsp ready tied high -> grants alternate 0,1,0,1 and responses return entries 3,7,3,7 every 3 cycles. With RR off -> only requester 0 is served.
REQ-034 rsp1_ready held low for 10 cycles in RESP -> rsp1_valid and rsp_val stay stable, busy=1, req0_ready stays 0 even with req0_valid=1. req0 is accepted in the cycle after the handshake completes.
REQ-035 Reset pulsed in the LOOKUP cycle -> the next cycle shows IDLE, busy=0, no rspN_valid. The next request receives the correct value.
REQ-036 lookup_cnt preloaded near 16'hFFFE via 3 completions -> it reaches 16'hFFFF and holds there.
REQ-037 sel=31 and sel=0 boundary entries -> rsp_val equals the corresponding table values, with full VAL_W width and no truncation.

Source files
------------

// File: rtl/lut_arbiter.sv
// Two-requester arbiter in front of a combinational lookup table: one lookup in flight at a time.
// Define LUT_ARBITER_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module lut_arbiter #(
  parameter int SEL_W = 5,
  parameter int VAL_W = 47
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic [SEL_W-1:0] req1_sel,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [VAL_W-1:0] rsp_val,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [SEL_W-1:0] lut_sel,
  input  logic [VAL_W-1:0] lut_val,
  output logic             busy,
  output logic [15:0]      lookup_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   gnt;           // requester owning the in-flight lookup
  logic   pick;          // arbitration winner while in IDLE
  logic   contend_pick;  // winner when both requesters are valid
  logic   accept;
  logic   done;

`ifdef LUT_ARBITER_RR_EN
  logic last_gnt;

  // Starts at requester 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if (accept) begin
      last_gnt <= pick;
    end
  end

  assign contend_pick = ~last_gnt;
`else
  assign contend_pick = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no latch is inferred.
    pick = 1'b0;
    if (req0_valid && req1_valid) begin
      pick = contend_pick;
    end else if (req1_valid) begin
      pick = 1'b1;
    end
  end

  assign accept = (state == IDLE) && !reset && (req0_valid || req1_valid);
  assign done   = (state == RESP) && (gnt ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = accept && !pick;
        req1_ready = accept && pick;
        if (accept) begin
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = !gnt;
        rsp1_valid = gnt;
        if (done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      lut_sel    <= '0;
      rsp_val    <= '0;
      lookup_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        gnt     <= pick;
        lut_sel <= pick ? req1_sel : req0_sel;
      end
      if (state == LOOKUP) begin
        rsp_val <= lut_val;
      end
      if (done && (lookup_cnt != 16'hFFFF)) begin
        lookup_cnt <= lookup_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_lut_arbiter.sv
// Directed bench for lut_arbiter: a scoreboard queue holds expected responses pushed at
// request acceptance and popped when the matching response is presented.
module tb_lut_arbiter;

  localparam int SEL_W = 5;
  localparam int VAL_W = 47;

  typedef struct packed {
    logic             who;
    logic [VAL_W-1:0] val;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [SEL_W-1:0] req0_sel, req1_sel;
  logic             req0_ready, req1_ready;
  logic             rsp0_valid, rsp1_valid;
  logic [VAL_W-1:0] rsp_val;
  logic             rsp0_ready, rsp1_ready;
  logic [SEL_W-1:0] lut_sel;
  logic [VAL_W-1:0] lut_val;
  logic             busy;
  logic [15:0]      lookup_cnt;

  logic [VAL_W-1:0] lut_mem [32];
  exp_t             sb [$];
  int               vectors     = 0;
  int               miscompares = 0;
  logic [15:0]      exp_cnt     = 16'd0;

  assign lut_val = lut_mem[lut_sel];

  always #5 clk = ~clk;

  lut_arbiter #(.SEL_W(SEL_W), .VAL_W(VAL_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_sel   (req0_sel),
    .req1_sel   (req1_sel),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_val    (rsp_val),
    .rsp0_ready (rsp0_ready),
    .rsp1_ready (rsp1_ready),
    .lut_sel    (lut_sel),
    .lut_val    (lut_val),
    .busy       (busy),
    .lookup_cnt (lookup_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed response with empty scoreboard, expected none", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_rsp0_valid"}, rsp0_valid, e.who == 1'b0);
      check({tag, "_rsp1_valid"}, rsp1_valid, e.who == 1'b1);
      check({tag, "_rsp_val"}, rsp_val, e.val);
    end
  endtask

  task automatic bump_cnt();
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  // One complete transaction from a lone requester; entered right after next().
  task automatic serve_one(input logic who, input logic [SEL_W-1:0] sel, input string tag);
    exp_t e;
    if (who) begin
      req1_valid = 1'b1;
      req1_sel   = sel;
    end else begin
      req0_valid = 1'b1;
      req0_sel   = sel;
    end
    settle();
    check({tag, "_req0_ready"}, req0_ready, !who);
    check({tag, "_req1_ready"}, req1_ready, who);
    e.who = who;
    e.val = lut_mem[sel];
    sb.push_back(e);
    next();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    settle();
    check({tag, "_lut_sel"}, lut_sel, sel);
    check({tag, "_busy_lookup"}, busy, 1'b1);
    next();
    settle();
    expect_rsp(tag);
    bump_cnt();
    next();
    settle();
    check({tag, "_rsp_done"}, {rsp0_valid, rsp1_valid}, 2'b00);
    check({tag, "_busy_idle"}, busy, 1'b0);
    check({tag, "_cnt"}, lookup_cnt, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] r;
    logic        g;
    for (int i = 0; i < 32; i++) begin
      r = {$urandom(), $urandom()};
      lut_mem[i] = r[VAL_W-1:0];
    end
    lut_mem[0]  = 47'h7FFF_FFFF_FFFF;
    lut_mem[31] = 47'h4000_0000_0001;
    lut_mem[3]  = 47'h1234_5678_9ABC;
    lut_mem[7]  = 47'h0FED_CBA9_8765;
    lut_mem[5]  = 47'h5555_AAAA_5555;
    lut_mem[9]  = 47'h2468_ACE0_1357;
    lut_mem[20] = 47'h3141_5926_5358;

    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_sel = '0; req1_sel = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset state and ready suppression while reset is high
    next();
    req0_valid = 1'b1;
    settle();
    check("ready_in_reset", req0_ready, 1'b0);
    next();
    reset = 1'b0;
    req0_valid = 1'b0;
    settle();
    check("rst_busy", busy, 1'b0);
    check("rst_lut_sel", lut_sel, 5'd0);
    check("rst_rsp_val", rsp_val, 47'd0);
    check("rst_cnt", lookup_cnt, 16'd0);
    check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);

    // Basic single lookup, sel=5
    next();
    serve_one(1'b0, 5'd5, "basic");

    // Stalled response for requester 1 with requester 0 waiting
    next();
    rsp1_ready = 1'b0;
    req1_valid = 1'b1;
    req1_sel   = 5'd9;
    settle();
    check("stall_req1_ready", req1_ready, 1'b1);
    check("stall_req0_ready_idle", req0_ready, 1'b0);
    sb.push_back('{who: 1'b1, val: lut_mem[9]});
    next();
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    req0_sel   = 5'd20;
    settle();
    check("stall_req0_ready_lookup", req0_ready, 1'b0);
    next();
    settle();
    expect_rsp("stall");
    for (int i = 0; i < 10; i++) begin
      next();
      settle();
      check("stall_rsp1_valid", rsp1_valid, 1'b1);
      check("stall_rsp0_valid", rsp0_valid, 1'b0);
      check("stall_rsp_val", rsp_val, lut_mem[9]);
      check("stall_busy", busy, 1'b1);
      check("stall_req0_ready", req0_ready, 1'b0);
    end
    rsp1_ready = 1'b1;
    bump_cnt();
    next();
    settle();
    check("stall_rsp1_drop", rsp1_valid, 1'b0);
    check("stall_cnt", lookup_cnt, exp_cnt);
    check("after_stall_req0_ready", req0_ready, 1'b1);
    sb.push_back('{who: 1'b0, val: lut_mem[20]});
    next();
    req0_valid = 1'b0;
    settle();
    check("after_stall_busy", busy, 1'b1);
    next();
    settle();
    expect_rsp("after_stall");
    bump_cnt();
    next();
    settle();
    check("after_stall_cnt", lookup_cnt, exp_cnt);

    // Reset during LOOKUP discards the in-flight request
    next();
    req0_valid = 1'b1;
    req0_sel   = 5'd12;
    settle();
    check("abort_req0_ready", req0_ready, 1'b1);
    next();
    req0_valid = 1'b0;
    reset = 1'b1;
    settle();
    check("abort_busy_lookup", busy, 1'b1);
    next();
    reset = 1'b0;
    exp_cnt = 16'd0;
    settle();
    check("abort_busy", busy, 1'b0);
    check("abort_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    check("abort_cnt", lookup_cnt, 16'd0);
    next();
    settle();
    check("abort_no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);

    // Boundary table entries at full width
    next();
    serve_one(1'b0, 5'd31, "sel31");
    next();
    serve_one(1'b1, 5'd0, "sel0");

    // Continuous contention with ready tied high
    next();
    reset = 1'b1;
    next();
    reset = 1'b0;
    exp_cnt = 16'd0;
    req0_valid = 1'b1; req0_sel = 5'd3;
    req1_valid = 1'b1; req1_sel = 5'd7;
    for (int k = 0; k < 4; k++) begin
`ifdef LUT_ARBITER_RR_EN
      g = (k % 2) == 1;
`else
      g = 1'b0;
`endif
      settle();
      check("contend_req0_ready", req0_ready, !g);
      check("contend_req1_ready", req1_ready, g);
      sb.push_back('{who: g, val: g ? lut_mem[7] : lut_mem[3]});
      next();
      settle();
      check("contend_ready_lookup", {req0_ready, req1_ready}, 2'b00);
      next();
      settle();
      expect_rsp("contend");
      bump_cnt();
      next();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    settle();
    check("contend_cnt", lookup_cnt, exp_cnt);

    // Saturation of the completion counter
    next();
    force dut.lookup_cnt = 16'hFFFD;
    next();
    release dut.lookup_cnt;
    exp_cnt = 16'hFFFD;
    settle();
    check("sat_preload", lookup_cnt, exp_cnt);
    for (int k = 0; k < 3; k++) begin
      next();
      serve_one(k[0], 5'(k + 1), "sat");
    end
    check("sat_final", lookup_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
